// File: rtl/apb_regbank_slave.sv
// APB4 completer exposing a bank of byte-strobed registers with optional wait states.
// Register 0 is a read-only ID word; faulting transfers complete with pslverr and no side effects.
module apb_regbank_slave #(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned NUM_REGS    = 16,
    parameter int unsigned WAIT_STATES = 0,
    parameter logic [31:0] ID_VALUE    = 32'h5350_4901
) (
    input  logic                           pclk,
    input  logic                           preset_n,
    input  logic                           psel,
    input  logic                           penable,
    input  logic                           pwrite,
    input  logic [ADDR_WIDTH-1:0]          paddr,
    input  logic [DATA_WIDTH-1:0]          pwdata,
    input  logic [DATA_WIDTH/8-1:0]        pstrb,
    output logic [DATA_WIDTH-1:0]          prdata,
    output logic                           pready,
    output logic                           pslverr,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q
);

    localparam int unsigned NBYTES = DATA_WIDTH / 8;
    localparam int unsigned LSB    = $clog2(NBYTES);
    localparam int unsigned IDXW   = $clog2(NUM_REGS);

    // One extra bit so the span itself is representable when it equals 2**ADDR_WIDTH.
    localparam logic [ADDR_WIDTH:0]   SPAN       = (ADDR_WIDTH + 1)'(NUM_REGS * NBYTES);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(NBYTES - 1);
    localparam logic [DATA_WIDTH-1:0] ID_WORD    = DATA_WIDTH'(ID_VALUE);

    localparam logic StIdle   = 1'b0;
    localparam logic StAccess = 1'b1;

    logic                                   state_q, state_d;
    logic [3:0]                             cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]                  addr_q, addr_d;
    logic                                   write_q, write_d;
    logic [DATA_WIDTH-1:0]                  wdata_q, wdata_d;
    logic [NBYTES-1:0]                      strb_q, strb_d;
    logic [NUM_REGS-1:0][DATA_WIDTH-1:0]    bank_q, bank_d;

    logic [IDXW-1:0] idx;
    logic            out_of_range;
    logic            misaligned;
    logic            ro_write;
    logic            err;
    logic            complete;

    // Error decode uses only the latched transfer, so bus changes in the access phase are inert.
    assign idx          = addr_q[LSB +: IDXW];
    assign out_of_range = {1'b0, addr_q} >= SPAN;
    assign misaligned   = (addr_q & ALIGN_MASK) != '0;
    assign ro_write     = write_q && (idx == '0);
    assign err          = out_of_range || misaligned || ro_write;
    assign complete     = (state_q == StAccess) && (cnt_q == '0) && psel && penable;

    always_comb begin
        pready  = complete;
        pslverr = complete && err;
        prdata  = '0;
        if (complete && !err && !write_q) begin
            prdata = bank_q[idx];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        write_d = write_q;
        wdata_d = wdata_q;
        strb_d  = strb_q;
        bank_d  = bank_q;

        if (psel && !penable) begin
            state_d = StAccess;
            cnt_d   = 4'(WAIT_STATES);
            addr_d  = paddr;
            write_d = pwrite;
            wdata_d = pwdata;
            strb_d  = pstrb;
        end else if (state_q == StAccess) begin
            if (!psel) begin
                state_d = StIdle;
                cnt_d   = '0;
            end else if (penable) begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = StIdle;
                end
            end
        end

        if (complete && write_q && !err) begin
            for (int unsigned b = 0; b < NBYTES; b++) begin
                if (strb_q[b]) begin
                    bank_d[idx][8*b +: 8] = wdata_q[8*b +: 8];
                end
            end
        end
        bank_d[0] = ID_WORD;
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            addr_q    <= '0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            strb_q    <= '0;
            bank_q    <= '0;
            bank_q[0] <= ID_WORD;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
            strb_q  <= strb_d;
            bank_q  <= bank_d;
        end
    end

    assign reg_q = bank_q;

endmodule
